// File: rtl/gate_test_pkg.sv
// Shared types and truth-table constants for the two-input gate checker.
package gate_test_pkg;

    // Sweep sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Expected Y per vector, bit index = {A,B}
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_truth_checker_settle_timer.sv
// Loadable down-counter that flags when the settle interval of a vector is used up.
module gate_settle_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    // Load on a new vector, otherwise count down towards zero and hold there
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Synthesizable stimulus/response checker: sweeps {A,B} through 00..11, samples Y
// after a programmable settle time and scores it against a truth table.
module gate_truth_checker
    import gate_test_pkg::*;
#(
    parameter logic [3:0]  TRUTH  = TT_NAND,
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    // Timer holds SETTLE-1 so that DRIVE lasts SETTLE cycles and CHECK adds the last one.
    localparam int unsigned    TW       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [TW-1:0]  LOAD_VAL = (SETTLE > 0) ? TW'(SETTLE - 1) : '0;
    // With no settle time each vector is sampled on the very next edge.
    localparam state_t         FIRST_ST = (SETTLE == 0) ? ST_CHECK : ST_DRIVE;

    state_t     r_state;
    logic [1:0] r_k;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err_count;
    logic [3:0] r_fail_mask;

    logic       w_accept;
    logic       w_load;
    logic       w_dec;
    logic       w_expired;
    logic       w_mismatch;

    assign w_accept   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
    assign w_load     = w_accept || ((r_state == ST_CHECK) && (r_k != 2'd3));
    assign w_dec      = (r_state == ST_DRIVE);
    assign w_mismatch = (Y != TRUTH[r_k]);

    gate_settle_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_dec),
        .o_expired  (w_expired)
    );

    // Sweep sequencer with registered stimulus and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_k         <= 2'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 3'd0;
            r_fail_mask <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_pass      <= 1'b0;
                        r_err_count <= 3'd0;
                        r_fail_mask <= 4'd0;
                        r_k         <= 2'd0;
                        r_a         <= 1'b0;
                        r_b         <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= FIRST_ST;
                    end
                end
                ST_DRIVE: begin
                    if (w_expired) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_mismatch) begin
                        r_fail_mask[r_k] <= 1'b1;
                        r_err_count      <= r_err_count + 3'd1;
                    end
                    if (r_k != 2'd3) begin
                        r_k     <= r_k + 2'd1;
                        {r_a, r_b} <= r_k + 2'd1;
                        r_state <= FIRST_ST;
                    end else begin
                        r_pass  <= (r_err_count == 3'd0) && !w_mismatch;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign A         = r_a;
    assign B         = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_mask = r_fail_mask;

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

- Self-checking hardware stimulus/response engine for two-input combinational gates.
- On `start`, drives all four input combinations onto a gate under test and samples its output after a programmable settle time.
- Compares each sample against a parameterised truth table and reports pass/fail, an error count and a per-vector failure mask.
- Sits beside a gate block on an FPGA test harness, replacing a simulation-only bench with a synthesizable checker.

## Interface
Parameters:
- `TRUTH`, default 4'b0111: expected Y per vector; bit index = {A,B}. The default is NAND.
- `SETTLE`, default 2: extra hold cycles per vector before Y is sampled. Range 0..15.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a sweep; sampled only when not busy
- `A`  out  1  gate input A, registered
- `B`  out  1  gate input B, registered
- `Y`  in  1  gate output under test
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse when results become valid
- `pass`  out  1  1 when all four vectors matched; held until the next accepted start
- `err_count`  out  3  number of mismatching vectors, 0..4
- `fail_mask`  out  4  bit k set when vector k mismatched

## Operation
- States:
  - IDLE: wait for `start`.
  - DRIVE: hold the current vector, count settle cycles.
  - CHECK: compare and advance.
  - DONE: results are valid.
- Vector order k = 0,1,2,3 maps to {A,B} = 00, 01, 10, 11.
- IDLE/DONE with `start`=1:
  - Clear `pass`, `err_count` and `fail_mask`.
  - Set k=0 and drive A,B=00.
  - Set `busy`=1 and enter DRIVE.
- DRIVE: stay until the settle counter reaches SETTLE (exactly SETTLE+1 cycles per vector including the CHECK edge), then go to CHECK.
- CHECK, at the edge that ends the vector:
  - If Y != TRUTH[k], set fail_mask[k] and increment err_count.
  - If k<3: drive vector k+1 and return to DRIVE.
  - Otherwise: go to DONE.
- Entry into DONE:
  - `busy`=0 and `done`=1 for exactly one cycle.
  - `pass` = (final err_count==0).
  - A,B return to 00.
- DONE behaves like IDLE; results persist.
- `start` while `busy`=1 is ignored. There is no queuing and no restart.
- Any value of Y other than 0 or 1 (X/Z in simulation) counts as a mismatch. Compare with a case-equality-safe expression in the model only; the RTL uses plain inequality.
- `err_count` never wraps: the maximum is 4, which fits in 3 bits.

## Timing
- Reset values: A=0, B=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, state IDLE.
- Sweep timing, with start accepted at edge E0:
  - Vector k is driven from edge E0+k·(SETTLE+1).
  - Vector k is sampled at edge E0+(k+1)·(SETTLE+1).
  - `done`, `pass`, `err_count` and `fail_mask` update at edge E0+4·(SETTLE+1). With SETTLE=2 this is E0+12.
- SETTLE=0: one cycle per vector; Y is sampled at the first edge after the vector is driven.
- `start` held high continuously: a new sweep starts on the edge after `done` (from DONE). The `done` pulse still lasts one cycle.
- Reset asserted mid-sweep:
  - All outputs take their reset values immediately (asynchronous).
  - The partial results are discarded.
  - After release, the block waits in IDLE for a fresh `start`.

## Structure
- Shared package `gate_test_pkg`:
  - State enum (IDLE, DRIVE, CHECK, DONE).
  - Truth-table constants: TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001.
- One natural sub-module, `gate_settle_timer`:
  - Loadable down-counter of width $clog2(SETTLE+1), minimum 1.
  - Outputs an `expired` flag consumed by the FSM.
- Top level holds the FSM, the vector index k (2 bits) and the result registers.

## Test plan
- NAND gate wired A/B→Y, TRUTH=TT_NAND, SETTLE=2: pulse start → busy high for 12 cycles; A,B step 00,01,10,11 every 3 cycles; done at E0+12; pass=1, err_count=0, fail_mask=0000.
- Y tied to 1 (stuck-at-1), TRUTH=TT_NAND → pass=0, err_count=1, fail_mask=1000.
- AND gate wired, TRUTH=TT_NAND → err_count=4, fail_mask=1111, pass=0; then start with TRUTH=TT_AND instance → pass=1.
- SETTLE=0 with a NAND gate → done at E0+4, pass=1; a second start pulse at E0+2 is ignored (no extra done, vector order intact).
- Reset asserted at E0+5 of a sweep → same cycle: A=B=0, busy=0, results zero; after release, no activity until start; the subsequent full sweep passes.
- start held high for 30 cycles with SETTLE=2 → done pulses at E0+12 and again 13 cycles later; each pulse lasts one cycle; results are cleared at each restart.
